data_mem_responder: RTL and testbench

// - Responder side of the processor's data-memory bus: serves load/store requests issued by the

---
 rtl/data_mem_responder_pkg.sv | 21 ++
 rtl/data_mem_responder_sync2.sv | 26 ++
 rtl/data_mem_responder.sv | 162 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared address map and FSM encodings for the data-memory responder.
package mem_map;

  localparam logic [7:0] ADDR_LED  = 8'h80;
  localparam logic [7:0] ADDR_SW   = 8'h81;
  localparam int         RAM_DEPTH = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_LED  = 2'd1,
    REG_SW   = 2'd2,
    REG_NONE = 2'd3
  } region_e;

endpackage

// File: rtl/data_mem_responder_sync2.sv
// Two-flop synchronizer for asynchronous board inputs, cleared to zero on reset.
module sync2 #(
  parameter int W = 1
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/data_mem_responder.sv
// Handshaked data-memory slave: word RAM plus LED register and switch port,
// with a programmable number of wait states before each acknowledge.
module data_mem_responder
  import mem_map::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int RAM_DEPTH   = 128,
  parameter int WAIT_STATES = 1,
  parameter int LED_W       = 10,
  parameter int SW_W        = 10
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              req,
  input  logic              wren,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  output logic              err,
  input  logic [SW_W-1:0]   SW,
  output logic [LED_W-1:0]  LEDR
);

  localparam int         RAM_AW  = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [2:0] WS_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              accept;
  logic              access;
  region_e           region;

  logic [ADDR_W-1:0] lat_addr_q;
  logic [DATA_W-1:0] lat_wdata_q;
  logic              lat_wren_q;

  logic [LED_W-1:0]  led_q;
  logic [SW_W-1:0]   sw_sync;
  logic [DATA_W-1:0] io_rd_q;
  logic              rd_from_ram_q;

  logic [DATA_W-1:0] ram [RAM_DEPTH];
  logic [DATA_W-1:0] ram_rd_q;
  logic [RAM_AW-1:0] ram_idx;

  sync2 #(.W(SW_W)) u_sw_sync (
    .Clock  (Clock),
    .Resetn (Resetn),
    .d_i    (SW),
    .q_o    (sw_sync)
  );

  // Decode always works on the latched address so mid-transaction input changes are harmless
  always_comb begin
    region = REG_NONE;
    if ({1'b0, lat_addr_q} < (ADDR_W+1)'(RAM_DEPTH)) begin
      region = REG_RAM;
    end else if (lat_addr_q == ADDR_W'(ADDR_LED)) begin
      region = REG_LED;
    end else if (lat_addr_q == ADDR_W'(ADDR_SW)) begin
      region = REG_SW;
    end
  end

  assign ram_idx = lat_addr_q[RAM_AW-1:0];

  // A request still high during the ack cycle is held off until the following idle cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    accept  = 1'b0;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && !ack_q) begin
          accept = 1'b1;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = WS_INIT;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        access  = 1'b1;
        ack_d   = 1'b1;
        err_d   = (region == REG_NONE);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q       <= IDLE;
      cnt_q         <= 3'd0;
      ack_q         <= 1'b0;
      err_q         <= 1'b0;
      led_q         <= '0;
      io_rd_q       <= '0;
      rd_from_ram_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      if (access && lat_wren_q && (region == REG_LED)) begin
        led_q <= lat_wdata_q[LED_W-1:0];
      end
      if (access && !lat_wren_q) begin
        rd_from_ram_q <= (region == REG_RAM);
        case (region)
          REG_LED: io_rd_q <= DATA_W'(led_q);
          REG_SW:  io_rd_q <= DATA_W'(sw_sync);
          default: io_rd_q <= '0;
        endcase
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (accept) begin
      lat_addr_q  <= addr;
      lat_wdata_q <= wdata;
      lat_wren_q  <= wren;
    end
  end

  // Unreset RAM with a registered read port so it can map onto block memory
  always_ff @(posedge Clock) begin
    if (access && (region == REG_RAM)) begin
      if (lat_wren_q) begin
        ram[ram_idx] <= lat_wdata_q;
      end else begin
        ram_rd_q <= ram[ram_idx];
      end
    end
  end

  assign rdata = rd_from_ram_q ? ram_rd_q : io_rd_q;
  assign ack   = ack_q;
  assign err   = err_q;
  assign busy  = (state_q != IDLE) || ack_q;
  assign LEDR  = led_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder: three instances with 1, 3 and 0 wait states
// checked against an array-based behavioural model of the memory map.
module tb_data_mem_responder;

  logic             clk;
  logic [2:0]       rstn_v, req_v, wren_v, ack_v, busy_v, err_v;
  logic [2:0][7:0]  addr_v;
  logic [2:0][15:0] wdata_v, rdata_v;
  logic [2:0][9:0]  sw_v, ledr_v;

  logic [15:0] mram    [3][128];
  logic [9:0]  mled    [3];
  logic [9:0]  msw     [3];
  logic [15:0] last_rd [3];

  int n_chk;
  int n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_responder #(
      .ADDR_W      (8),
      .DATA_W      (16),
      .RAM_DEPTH   (128),
      .WAIT_STATES ((g == 0) ? 1 : ((g == 1) ? 3 : 0)),
      .LED_W       (10),
      .SW_W        (10)
    ) u_dut (
      .Clock  (clk),
      .Resetn (rstn_v[g]),
      .req    (req_v[g]),
      .wren   (wren_v[g]),
      .addr   (addr_v[g]),
      .wdata  (wdata_v[g]),
      .rdata  (rdata_v[g]),
      .ack    (ack_v[g]),
      .busy   (busy_v[g]),
      .err    (err_v[g]),
      .SW     (sw_v[g]),
      .LEDR   (ledr_v[g])
    );
  end

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 0);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic set_sw(input int d, input logic [9:0] v);
    @(negedge clk);
    sw_v[d] = v;
    repeat (3) @(posedge clk);
    msw[d] = v;
  endtask

  // One complete transaction: model update, drive, latency/ack/err/rdata/busy checks
  task automatic do_txn(input int d, input bit we, input logic [7:0] a, input logic [15:0] wd);
    logic [15:0] exp_rd;
    bit          exp_err;
    int          lat;
    exp_err = !((a < 8'd128) || (a == 8'h80) || (a == 8'h81));
    if (we) begin
      if (a < 8'd128) mram[d][a] = wd;
      else if (a == 8'h80) mled[d] = wd[9:0];
    end else begin
      if (a < 8'd128) last_rd[d] = mram[d][a];
      else if (a == 8'h80) last_rd[d] = {6'b0, mled[d]};
      else if (a == 8'h81) last_rd[d] = {6'b0, msw[d]};
      else last_rd[d] = 16'h0000;
    end
    exp_rd = last_rd[d];

    @(negedge clk);
    req_v[d]   = 1'b1;
    wren_v[d]  = we;
    addr_v[d]  = a;
    wdata_v[d] = wd;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        addr_v[d]  = 8'($urandom);
        wdata_v[d] = 16'($urandom);
      end
      if (!ack_v[d]) check($sformatf("d%0d busy_wait", d), 32'(busy_v[d]), 32'd1);
    end while (!ack_v[d] && lat < 20);
    check($sformatf("d%0d ack_latency a=%0h", d, a), 32'(lat), 32'(ws_of(d) + 2));
    if (ack_v[d]) begin
      check($sformatf("d%0d err a=%0h", d, a), 32'(err_v[d]), 32'(exp_err));
      check($sformatf("d%0d busy_ack", d), 32'(busy_v[d]), 32'd1);
      check($sformatf("d%0d rdata a=%0h we=%0d", d, a, we), 32'(rdata_v[d]), 32'(exp_rd));
    end
    @(negedge clk);
    req_v[d] = 1'b0;
    @(posedge clk);
    #1;
    check($sformatf("d%0d ack_after", d), 32'(ack_v[d]), 32'd0);
    check($sformatf("d%0d err_after", d), 32'(err_v[d]), 32'd0);
    check($sformatf("d%0d busy_after", d), 32'(busy_v[d]), 32'd0);
    check($sformatf("d%0d ledr", d), 32'(ledr_v[d]), 32'(mled[d]));
  endtask

  initial begin
    logic [7:0]  a;
    logic [15:0] wd;
    int          d;
    int          r;
    n_chk   = 0;
    n_pass  = 0;
    rstn_v  = 3'b000;
    req_v   = 3'b000;
    wren_v  = 3'b000;
    addr_v  = '0;
    wdata_v = '0;
    sw_v    = '0;
    for (int i = 0; i < 3; i++) begin
      mled[i]    = 10'h0;
      msw[i]     = 10'h0;
      last_rd[i] = 16'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("d%0d rst_ack", i), 32'(ack_v[i]), 32'd0);
      check($sformatf("d%0d rst_busy", i), 32'(busy_v[i]), 32'd0);
      check($sformatf("d%0d rst_err", i), 32'(err_v[i]), 32'd0);
      check($sformatf("d%0d rst_rdata", i), 32'(rdata_v[i]), 32'd0);
      check($sformatf("d%0d rst_ledr", i), 32'(ledr_v[i]), 32'd0);
    end
    @(negedge clk);
    rstn_v = 3'b111;

    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 128; k++)
        do_txn(i, 1'b1, 8'(k), 16'($urandom));

    // Directed, one wait state
    do_txn(0, 1'b1, 8'h05, 16'h1234);
    do_txn(0, 1'b0, 8'h05, 16'h0000);
    check("dir ram_load", 32'(rdata_v[0]), 32'h1234);
    do_txn(0, 1'b1, 8'h80, 16'hFFFF);
    check("dir led_store", 32'(ledr_v[0]), 32'h3FF);
    do_txn(0, 1'b0, 8'h80, 16'h0000);
    check("dir led_load", 32'(rdata_v[0]), 32'h03FF);
    set_sw(0, 10'h2A5);
    do_txn(0, 1'b0, 8'h81, 16'h0000);
    check("dir sw_load", 32'(rdata_v[0]), 32'h02A5);
    do_txn(0, 1'b1, 8'h81, 16'h5555);
    check("dir sw_store_led", 32'(ledr_v[0]), 32'h3FF);
    do_txn(0, 1'b0, 8'h05, 16'h0000);
    check("dir sw_store_ram", 32'(rdata_v[0]), 32'h1234);
    do_txn(0, 1'b1, 8'hC0, 16'h7777);
    do_txn(0, 1'b0, 8'hC0, 16'h0000);
    check("dir unmapped_load", 32'(rdata_v[0]), 32'h0000);
    do_txn(0, 1'b0, 8'h80, 16'h0000);
    check("dir unmapped_noeffect", 32'(rdata_v[0]), 32'h03FF);

    // Reset in the middle of a three-wait-state store
    do_txn(1, 1'b1, 8'h10, 16'h0001);
    @(negedge clk);
    req_v[1]   = 1'b1;
    wren_v[1]  = 1'b1;
    addr_v[1]  = 8'h10;
    wdata_v[1] = 16'hBEEF;
    @(posedge clk);
    #1;
    check("rst_mid busy_wait", 32'(busy_v[1]), 32'd1);
    #2;
    rstn_v[1] = 1'b0;
    #1;
    check("rst_mid busy", 32'(busy_v[1]), 32'd0);
    check("rst_mid rdata", 32'(rdata_v[1]), 32'd0);
    check("rst_mid ledr", 32'(ledr_v[1]), 32'd0);
    req_v[1] = 1'b0;
    @(negedge clk);
    rstn_v[1]  = 1'b1;
    mled[1]    = 10'h0;
    last_rd[1] = 16'h0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      check("rst_mid no_ack", 32'(ack_v[1]), 32'd0);
    end
    do_txn(1, 1'b0, 8'h10, 16'h0000);
    check("rst_mid ram_kept", 32'(rdata_v[1]), 32'h0001);

    // Zero wait states with req held high across three loads
    @(negedge clk);
    req_v[2]  = 1'b1;
    wren_v[2] = 1'b0;
    addr_v[2] = 8'h05;
    last_rd[2] = mram[2][5];
    for (int k = 0; k < 9; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("held busy k=%0d", k), 32'(busy_v[2]), 32'((k % 3) != 2));
      check($sformatf("held ack k=%0d", k), 32'(ack_v[2]), 32'((k % 3) == 1));
      if ((k % 3) == 1) check($sformatf("held rdata k=%0d", k), 32'(rdata_v[2]), 32'(mram[2][5]));
    end
    @(negedge clk);
    req_v[2] = 1'b0;
    @(posedge clk);
    #1;
    check("held idle", 32'(busy_v[2]), 32'd0);

    // Random traffic across all three instances
    for (int n = 0; n < 200; n++) begin
      d = int'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) set_sw(d, 10'($urandom));
      r = int'($urandom_range(0, 9));
      if (r < 6) a = 8'($urandom_range(0, 127));
      else if (r == 6) a = 8'h80;
      else if (r == 7) a = 8'h81;
      else a = 8'($urandom_range(8'h82, 8'hFF));
      wd = 16'($urandom);
      do_txn(d, 1'($urandom), a, wd);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
